// File: rtl/vedic_pkg.sv
// -----------------------------------------------------------------------------
// vedic_pkg
// Shared definitions for the Vedic multiply-accumulate block.
//   state_t : frame controller states (IDLE, RUN, DRAIN, DONE)
//   PROD_W  : width of the unsigned 8x8 product
// -----------------------------------------------------------------------------
package vedic_pkg;

    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : vedic_pkg

// File: rtl/vedic_mac_accum_if.sv
// -----------------------------------------------------------------------------
// vedic_mac_accum_if
// Operand stream and result handshake of the Vedic MAC accumulator.
//   start/len              : frame request (length in operand pairs)
//   in_valid/in_ready/a/b  : operand-pair stream
//   out_valid/out_ready    : result handshake
//   out_acc/out_ovf        : frame sum and sticky overflow
// master = frame producer/result consumer, slave = the accumulator.
// -----------------------------------------------------------------------------
interface vedic_mac_accum_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface : vedic_mac_accum_if

// File: rtl/vedic8x8.sv
// -----------------------------------------------------------------------------
// vedic8x8
// Unsigned 8x8 multiplier built from the Urdhva-Tiryagbhyam structure:
// 2x2 bit-level cells combined into 4x4 blocks, combined into the 8x8.
//   a, b : unsigned operands
//   p    : 16-bit product (purely combinational)
// -----------------------------------------------------------------------------
module vedic8x8
    import vedic_pkg::*;
(
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [PROD_W-1:0] p
);

    // 2x2 cell: partial-product ANDs folded with two half adders.
    function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, t3, c1;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        c1 = t1 & t2;
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    // 4x4 block: four 2x2 cells, cross terms shifted by two bits.
    function automatic logic [7:0] v4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = v2x2(x[1:0], y[1:0]);
        q1 = v2x2(x[3:2], y[1:0]);
        q2 = v2x2(x[1:0], y[3:2]);
        q3 = v2x2(x[3:2], y[3:2]);
        return {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
    endfunction

    // 8x8 block: four 4x4 blocks, cross terms shifted by four bits.
    function automatic logic [15:0] v8x8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = v4x4(x[3:0], y[3:0]);
        q1 = v4x4(x[7:4], y[3:0]);
        q2 = v4x4(x[3:0], y[7:4]);
        q3 = v4x4(x[7:4], y[7:4]);
        return {8'h00, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0} + {q3, 8'h00};
    endfunction

    assign p = v8x8(a, b);

endmodule : vedic8x8

// File: rtl/vedic_mac_accum.sv
// -----------------------------------------------------------------------------
// vedic_mac_accum
// Frame-based multiply-accumulate. A frame of len operand pairs is accepted
// on the bus, each pair is registered, multiplied by vedic8x8 and added to
// the accumulator one cycle later. The frame sum (wrapping, with a sticky
// overflow flag) is presented with a valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vedic_mac_accum_if slave (start/len, operand stream, result)
// ACC_W and LEN_W must match the parameters of the connected interface.
// -----------------------------------------------------------------------------
module vedic_mac_accum
    import vedic_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    vedic_mac_accum_if.slave   bus
);

    state_t             state_r;
    state_t             state_nx_s;

    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [7:0]         a_r;
    logic [7:0]         b_r;
    logic               pipe_vld_r;
    logic [ACC_W-1:0]   acc_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               last_beat_s;
    logic               frame_start_s;
    logic [PROD_W-1:0]  prod_s;
    logic [ACC_W:0]     sum_s;

    vedic8x8 u_mul (
        .a (a_r),
        .b (b_r),
        .p (prod_s)
    );

    // Handshake decode and the widened sum whose top bit is the carry out.
    always_comb begin
        accept_s      = bus.in_valid & in_ready_r;
        last_beat_s   = (cnt_r == (len_r - LEN_W'(1)));
        frame_start_s = (state_r == IDLE) & bus.start;
        sum_s         = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_s};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != LEN_W'(0)) begin
                        state_nx_s = RUN;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && last_beat_s) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DRAIN: begin
                // The last product is added during this cycle.
                state_nx_s = DONE;
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == RUN);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Datapath: operand capture, beat counting, accumulation, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_r      <= LEN_W'(0);
            cnt_r      <= LEN_W'(0);
            a_r        <= 8'd0;
            b_r        <= 8'd0;
            pipe_vld_r <= 1'b0;
            acc_r      <= ACC_W'(0);
            ovf_r      <= 1'b0;
        end else if (frame_start_s) begin
            len_r      <= bus.len;
            cnt_r      <= LEN_W'(0);
            pipe_vld_r <= 1'b0;
            acc_r      <= ACC_W'(0);
            ovf_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r        <= bus.a;
                b_r        <= bus.b;
                cnt_r      <= cnt_r + LEN_W'(1);
                pipe_vld_r <= 1'b1;
            end else begin
                pipe_vld_r <= 1'b0;
            end
            if (pipe_vld_r) begin
                acc_r <= sum_s[ACC_W-1:0];
                ovf_r <= ovf_r | sum_s[ACC_W];
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_acc   = acc_r;
    assign bus.out_ovf   = ovf_r;

endmodule : vedic_mac_accum

// File: tb/tb_vedic_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_vedic_mac_accum
// Directed bench for vedic_mac_accum. Two instances (ACC_W=24 and ACC_W=16)
// receive identical stimulus; expected sums are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_vedic_mac_accum;

    logic clk = 1'b0;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vedic_mac_accum_if #(.ACC_W(24), .LEN_W(8)) bus0 ();
    vedic_mac_accum_if #(.ACC_W(16), .LEN_W(8)) bus1 ();

    assign bus1.start     = bus0.start;
    assign bus1.len       = bus0.len;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.a         = bus0.a;
    assign bus1.b         = bus0.b;
    assign bus1.out_ready = bus0.out_ready;

    vedic_mac_accum #(.ACC_W(24), .LEN_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    vedic_mac_accum #(.ACC_W(16), .LEN_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] n);
        bus0.start = 1'b1;
        bus0.len   = n;
        tick();
        bus0.start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] x, input logic [7:0] y, input int gap);
        int i;
        bus0.in_valid = 1'b1;
        bus0.a        = x;
        bus0.b        = y;
        i = 0;
        while (!bus0.in_ready && i < 20) begin
            tick();
            i++;
        end
        check_vec("beat_in_ready", 32'(bus0.in_ready), 32'd1);
        tick();
        bus0.in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!bus0.out_valid && i < 20) begin
            tick();
            i++;
        end
        check_vec("done_out_valid", 32'(bus0.out_valid), 32'd1);
    endtask

    task automatic finish_frame();
        bus0.out_ready = 1'b1;
        tick();
        bus0.out_ready = 1'b0;
        check_vec("idle_out_valid0", 32'(bus0.out_valid), 32'd0);
        check_vec("idle_out_valid1", 32'(bus1.out_valid), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_vec({tag, "_in_ready"},  32'(bus0.in_ready),  32'd0);
        check_vec({tag, "_out_valid"}, 32'(bus0.out_valid), 32'd0);
        check_vec({tag, "_acc0"},      32'(bus0.out_acc),   32'd0);
        check_vec({tag, "_ovf0"},      32'(bus0.out_ovf),   32'd0);
        check_vec({tag, "_acc1"},      32'(bus1.out_acc),   32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus0.start     = 1'b0;
        bus0.len       = 8'd0;
        bus0.in_valid  = 1'b0;
        bus0.a         = 8'd0;
        bus0.b         = 8'd0;
        bus0.out_ready = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Single beat 255*255 with exact two-cycle latency.
        start_frame(8'd1);
        check_vec("run_in_ready", 32'(bus0.in_ready), 32'd1);
        bus0.in_valid = 1'b1;
        bus0.a        = 8'd255;
        bus0.b        = 8'd255;
        tick();
        bus0.in_valid = 1'b0;
        check_vec("lat_t1_out_valid", 32'(bus0.out_valid), 32'd0);
        check_vec("drain_in_ready", 32'(bus0.in_ready), 32'd0);
        tick();
        check_vec("lat_t2_out_valid", 32'(bus0.out_valid), 32'd1);
        check_vec("sq255_acc0", 32'(bus0.out_acc), 32'd65025);
        check_vec("sq255_acc1", 32'(bus1.out_acc), 32'd65025);
        check_vec("sq255_ovf0", 32'(bus0.out_ovf), 32'd0);
        check_vec("sq255_ovf1", 32'(bus1.out_ovf), 32'd0);
        finish_frame();

        // Four beats with gaps: 15 + 63 + 256 + 0 = 334.
        start_frame(8'd4);
        send_beat(8'd3,  8'd5,   2);
        send_beat(8'd7,  8'd9,   1);
        send_beat(8'd16, 8'd16,  3);
        send_beat(8'd0,  8'd200, 0);
        wait_done();
        check_vec("gap_acc0", 32'(bus0.out_acc), 32'd334);
        check_vec("gap_acc1", 32'(bus1.out_acc), 32'd334);
        check_vec("gap_ovf0", 32'(bus0.out_ovf), 32'd0);
        finish_frame();

        // Zero-length frame goes straight to DONE with a cleared sum.
        bus0.start = 1'b1;
        bus0.len   = 8'd0;
        tick();
        bus0.start = 1'b0;
        check_vec("len0_out_valid", 32'(bus0.out_valid), 32'd1);
        check_vec("len0_acc0", 32'(bus0.out_acc), 32'd0);
        check_vec("len0_ovf0", 32'(bus0.out_ovf), 32'd0);
        check_vec("len0_in_ready", 32'(bus0.in_ready), 32'd0);
        finish_frame();

        // Overflow: 2*65025 = 130050; wraps to 64514 in 16 bits.
        start_frame(8'd2);
        send_beat(8'd255, 8'd255, 0);
        send_beat(8'd255, 8'd255, 0);
        wait_done();
        check_vec("ovf_acc1", 32'(bus1.out_acc), 32'd64514);
        check_vec("ovf_ovf1", 32'(bus1.out_ovf), 32'd1);
        check_vec("ovf_acc0", 32'(bus0.out_acc), 32'd130050);
        check_vec("ovf_ovf0", 32'(bus0.out_ovf), 32'd0);

        // Hold in DONE with out_ready low; a start pulse must be ignored.
        for (int k = 0; k < 5; k++) begin
            bus0.start = (k == 2);
            bus0.len   = 8'd3;
            tick();
            check_vec("hold_out_valid", 32'(bus1.out_valid), 32'd1);
            check_vec("hold_acc1", 32'(bus1.out_acc), 32'd64514);
            check_vec("hold_ovf1", 32'(bus1.out_ovf), 32'd1);
        end
        bus0.start = 1'b0;
        finish_frame();
        tick();
        check_vec("post_hold_in_ready", 32'(bus0.in_ready), 32'd0);
        check_vec("post_hold_acc1", 32'(bus1.out_acc), 32'd64514);

        // Reset mid-frame after two of four beats, then a fresh frame.
        start_frame(8'd4);
        send_beat(8'd10, 8'd10, 0);
        send_beat(8'd20, 8'd20, 0);
        tick();
        check_vec("mid_acc0", 32'(bus0.out_acc), 32'd500);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_quiet("midrst");
        tick();
        check_vec("midrst_idle_in_ready", 32'(bus0.in_ready), 32'd0);
        start_frame(8'd1);
        send_beat(8'd2, 8'd3, 0);
        wait_done();
        check_vec("after_rst_acc0", 32'(bus0.out_acc), 32'd6);
        check_vec("after_rst_acc1", 32'(bus1.out_acc), 32'd6);
        finish_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_vedic_mac_accum

// File: doc/vedic_mac_accum.md
VEDIC_MAC_ACCUM -- requirements
Module: vedic_mac_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator width in bits; legal range 16..32.
REQ-002 SHALL have parameter LEN_W, default 8: width of the beat-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: number of operand pairs in the frame; latched on start.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand pair is present on a and b.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-009 SHALL have ports a and b, input, 8 bits each: unsigned multiplicand and multiplier.
REQ-010 SHALL have port out_valid, output, 1 bit: the frame result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_acc, output, ACC_W bits: the sum of all products in the frame.
REQ-013 SHALL have port out_ovf, output, 1 bit: the frame sum exceeded 2^ACC_W-1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 In IDLE, start=1 with len!=0 SHALL latch len, clear the accumulator, clear ovf, and enter RUN.
REQ-016 In IDLE, start=1 with len=0 SHALL clear the accumulator and ovf and enter DONE directly.
REQ-017 SHALL drive in_ready=1 only in RUN.
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both 1; gaps in in_valid SHALL stall without loss.
REQ-019 SHALL register each accepted pair, multiply it as an unsigned 8x8 to 16-bit product, and add the zero-extended product to the accumulator on the following cycle.
REQ-020 Accumulation SHALL wrap modulo 2^ACC_W; any carry out of bit ACC_W-1 SHALL set a sticky ovf bit for the frame.
REQ-021 Acceptance of the len-th beat SHALL move the FSM RUN->DRAIN; DRAIN SHALL last exactly one cycle and then move to DONE.
REQ-022 Latency: if the last beat is accepted in cycle t, out_valid SHALL be 1 from cycle t+2.
REQ-023 In DONE, out_valid=1 and out_acc/out_ovf SHALL hold stable until out_valid and out_ready are both 1, then the FSM SHALL return to IDLE.
REQ-024 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-025 out_valid SHALL be 0 outside DONE; out_acc and out_ovf SHALL reflect the live accumulator at all times.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, accumulator=0, ovf=0, beat count=0, and the operand registers=0, from any state including mid-frame.
REQ-027 After reset, in_ready=0, out_valid=0, out_acc=0, out_ovf=0.

Structure
REQ-028 The state enumeration and the product width constant (16) SHALL be placed in the shared package vedic_pkg.
REQ-029 The product SHALL be computed by one instance of the existing sub-module vedic8x8; no behavioural multiply is permitted.

Verification
REQ-030 len=1, a=255, b=255 -> out_valid 2 cycles after accept, out_acc=65025 (0xFE01), out_ovf=0.
REQ-031 len=4, pairs (3,5), (7,9), (16,16), (0,200) with in_valid gaps between beats -> out_acc=334, out_ovf=0.
REQ-032 start with len=0 -> out_valid=1 on the next cycle, out_acc=0, in_ready never 1.
REQ-033 ACC_W=16, len=2, pairs (255,255) twice -> out_acc=64514, out_ovf=1.
REQ-034 In DONE, hold out_ready=0 for 5 cycles and pulse start -> out_valid and out_acc stable and start ignored; out_ready=1 -> IDLE on the next cycle.
REQ-035 rst_n=0 for one cycle after 2 of 4 beats -> next cycle IDLE, all outputs 0; a new frame len=1 with pair (2,3) -> out_acc=6.
